// File: rtl/FA_with_HA.sv
// rtl/FA_with_HA.sv - single-bit full adder built from two half-adder stages
//
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : carry out
module FA_with_HA (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // The first half-adder stage adds a and b.
  // The second stage folds in the carry.
  logic s1;
  logic c1;
  logic c2;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign sum  = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder around a single full adder
//
// Computes {carry_out, sum} = a + b + carry_in at one bit per clock, LSB first.
// A carry flop closes the loop between bit positions.
//
// Parameters:
//   WIDTH     : operand/sum width (>= 2)
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request a new operation (accepted only while idle)
//   a, b      : operands, sampled on the accepting edge
//   carry_in  : initial carry, sampled on the accepting edge
//   sub       : (only with SERIAL_ADDER_SUB_EN) 1 = compute a - b
//   busy      : high while bits are being processed
//   done      : one-cycle pulse when sum/carry_out are updated
//   sum       : registered result, held until the next completion
//   carry_out : registered final carry (no-borrow flag when subtracting)
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_c;

  logic [WIDTH-1:0] b_load;
  logic             cy_load;

  // Subtraction is a + ~b + 1.
  // The carry is therefore forced to 1, and its final value is the no-borrow flag.
  always_comb begin
    b_load  = b;
    cy_load = carry_in;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load  = ~b;
      cy_load = 1'b1;
    end
`endif
  end

  FA_with_HA u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (cy),
    .sum  (fa_s),
    .cout (fa_c)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // busy comes straight from the state flop, so it has no combinational input path.
  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh <= a;
        b_sh <= b_load;
        cy   <= cy_load;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sh <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh <= {1'b0, b_sh[WIDTH-1:1]};
        // Each new sum bit enters at the MSB.
        // After WIDTH shifts, bit 0 has reached the LSB.
        r_sh <= {fa_s, r_sh[WIDTH-1:1]};
        cy   <= fa_c;
        if (last) begin
          sum       <= {fa_s, r_sh[WIDTH-1:1]};
          carry_out <= fa_c;
          done      <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry_out;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // This task is called at a negedge.
  // It returns at the negedge of the done cycle, or after a 20-cycle timeout.
  // lat counts rising edges after the accepting edge up to the one that raised done.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        output int lat, output bit busy_ok);
    a        = ta;
    b        = tb_;
    carry_in = tc;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && lat < 20);
  endtask

  int lat;
  bit bok;
  int ndone;
  int first_lat;
  int busy_cycles;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub      = 1'b0;
`endif
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add: 0F + 01 = 10
    run_op(8'h0F, 8'h01, 1'b0, lat, bok);
    check("basic_lat", 32'(lat), 32'd8);
    check("basic_busy_held", 32'(bok), 32'd1);
    check("basic_busy_low_at_done", 32'(busy), 32'd0);
    check("basic_sum", 32'(sum), 32'h10);
    check("basic_cout", 32'(carry_out), 32'd0);
    @(negedge clk);
    check("basic_done_one_cycle", 32'(done), 32'd0);
    check("basic_sum_held", 32'(sum), 32'h10);

    // Carry out: FF + 01 + 1 = 1_01, and FF + 01 + 0 = 1_00
    run_op(8'hFF, 8'h01, 1'b1, lat, bok);
    check("cy1_lat", 32'(lat), 32'd8);
    check("cy1_sum", 32'(sum), 32'h01);
    check("cy1_cout", 32'(carry_out), 32'd1);
    @(negedge clk);
    run_op(8'hFF, 8'h01, 1'b0, lat, bok);
    check("cy0_sum", 32'(sum), 32'h00);
    check("cy0_cout", 32'(carry_out), 32'd1);
    @(negedge clk);

    // Start while busy: 12 + 34 = 46. The AA + 55 request three cycles in must be ignored.
    a = 8'h12; b = 8'h34; carry_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0; first_lat = 0; busy_cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        ndone++;
        if (first_lat == 0) first_lat = i;
        check("busy_ign_sum", 32'(sum), 32'h46);
        check("busy_ign_cout", 32'(carry_out), 32'd0);
      end
      if (i == 3) begin
        a = 8'hAA; b = 8'h55; start = 1'b1;
      end
    end
    check("busy_ign_ndone", 32'(ndone), 32'd1);
    check("busy_ign_lat", 32'(first_lat), 32'd8);
    // busy is sampled after edges k+1..k+7 while the operation runs.
    check("busy_ign_busy_len", 32'(busy_cycles), 32'd7);

    // Back-to-back: 80 + 80 = 1_00, then 01 + 02 = 03 issued in the done cycle.
    run_op(8'h80, 8'h80, 1'b0, lat, bok);
    check("b2b1_done", 32'(done), 32'd1);
    check("b2b1_sum", 32'(sum), 32'h00);
    check("b2b1_cout", 32'(carry_out), 32'd1);
    run_op(8'h01, 8'h02, 1'b0, lat, bok);
    check("b2b2_lat", 32'(lat), 32'd8);
    check("b2b2_sum", 32'(sum), 32'h03);
    check("b2b2_cout", 32'(carry_out), 32'd0);
    @(negedge clk);

    // Reset mid-operation, asserted between clock edges.
    a = 8'hFF; b = 8'hFF; carry_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'h00);
    check("mid_rst_cout", 32'(carry_out), 32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("mid_rst_no_done", 32'(ndone), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, lat, bok);
    check("post_rst_lat", 32'(lat), 32'd8);
    check("post_rst_sum", 32'(sum), 32'h02);
    check("post_rst_cout", 32'(carry_out), 32'd0);
    @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract: 05 - 07 = FE with a borrow; 07 - 05 = 02 with no borrow.
    // carry_in is deliberately set to 0; it must be ignored.
    sub = 1'b1;
    run_op(8'h05, 8'h07, 1'b0, lat, bok);
    check("sub1_sum", 32'(sum), 32'hFE);
    check("sub1_cout", 32'(carry_out), 32'd0);
    @(negedge clk);
    run_op(8'h07, 8'h05, 1'b0, lat, bok);
    check("sub2_sum", 32'(sum), 32'h02);
    check("sub2_cout", 32'(carry_out), 32'd1);
    @(negedge clk);
    sub = 1'b0;
    run_op(8'h07, 8'h05, 1'b0, lat, bok);
    check("sub0_add_sum", 32'(sum), 32'h0C);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
